vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_VISIBLE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, 0, asserted level of hsync/vsync; 0 means active-low.
REQ-010 clk  input  1  single system clock; all logic on rising edge.
REQ-011 reset  input  1  synchronous, active-low reset.
REQ-012 px_en  input  1  pixel-rate enable; counters advance only on clk edges where px_en=1.
REQ-013 x_px  output  10  current pixel column, 0..H_TOTAL-1.
REQ-014 y_px  output  10  current line, 0..V_TOTAL-1.
REQ-015 hsync  output  1  horizontal sync, at SYNC_POL while asserted.
REQ-016 vsync  output  1  vertical sync, at SYNC_POL while asserted.
REQ-017 active  output  1  high while (x_px,y_px) lies in the visible region.
REQ-018 line_start  output  1  one-clk pulse on the edge where x_px becomes 0.
REQ-019 frame_start  output  1  one-clk pulse on the edge where x_px and y_px both become 0.

Function
REQ-020 H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default) and V_TOTAL=V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525 by default); both SHALL be at most 1024, otherwise elaboration fails.
REQ-021 All outputs SHALL be registers; hsync, vsync and active SHALL always describe the x_px/y_px values presented in the same cycle, with zero skew.
REQ-022 On a px_en edge with x_px<H_TOTAL-1, x_px SHALL increment by 1 and y_px SHALL hold.
REQ-023 On a px_en edge with x_px=H_TOTAL-1, x_px SHALL wrap to 0, and y_px SHALL increment, or wrap to 0 if y_px=V_TOTAL-1.
REQ-024 With px_en=0, all counters and level outputs SHALL hold, and line_start/frame_start SHALL be 0.
REQ-025 hsync SHALL be asserted iff H_VISIBLE+H_FRONT <= x_px < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
REQ-026 vsync SHALL be asserted iff V_VISIBLE+V_FRONT <= y_px < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default), independent of x_px.
REQ-027 active SHALL be 1 iff x_px<H_VISIBLE and y_px<V_VISIBLE.
REQ-028 line_start SHALL be high for exactly one clk per line, on the px_en edge entering x_px=0, including the frame wrap.
REQ-029 frame_start SHALL be high for exactly one clk per frame, coincident with that frame's line_start.
REQ-030 Counter arithmetic is 10-bit unsigned; wrap SHALL be by compare to H_TOTAL-1/V_TOTAL-1, never by natural overflow.

Reset
REQ-031 While reset=0 at a clk edge, outputs SHALL load: x_px=H_TOTAL-1, y_px=V_TOTAL-1, hsync=vsync=!SYNC_POL, active=0, line_start=0, frame_start=0; px_en is ignored.
REQ-032 The first px_en edge after reset release SHALL move to (0,0) with line_start=frame_start=1 and active=1.
REQ-033 Reset asserted mid-frame SHALL take effect at the next clk edge, with no partial line or sync pulse continuing.

Verification
REQ-034 Reset pulse, then px_en=1 constant -> the first edge after release gives x=0, y=0, frame_start=1, line_start=1, active=1; x reaches 799 and then 0 at y=1.
REQ-035 Full-frame run, px_en=1 -> exactly 420000 clks between frame_starts; per line, hsync low for x=656..751 (96 clks); vsync low for y=490..491 (1600 clks); active count 307200 per frame.
REQ-036 px_en toggling 1,0,1,0 -> counters advance every other clk; frame period 840000 clks; line_start width exactly 1 clk.
REQ-037 Reset asserted at x=700, y=491 (hsync and vsync asserted) -> the next edge gives x=799, y=524, hsync=vsync=1, active=0.
REQ-038 SYNC_POL=1 with small timing (H: 4/1/2/1, V: 3/1/1/1) -> hsync high only at x=5..6, vsync high only at y=4; frame of 8x6 pixels = 48 enabled edges.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator: registered pixel/line counters with sync,
// active-video and line/frame start strobes derived from the next position.
module vga_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       px_en,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_badTiming
      $error("vga_timing: H_TOTAL and V_TOTAL must be in 1..1024");
    end
  endgenerate

  localparam logic [9:0]  H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [10:0] HA_END   = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VA_END   = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_active;
  logic       r_lineStart;
  logic       r_frameStart;

  logic       w_xLast;
  logic       w_yLast;
  logic [9:0] w_xNext;
  logic [9:0] w_yNext;
  logic       w_hsOn;
  logic       w_vsOn;
  logic       w_activeNext;

  // Level outputs are decoded from the next position so that, once registered,
  // they line up with the counter values they describe.
  always_comb begin
    w_xLast      = (r_x == H_MAX);
    w_yLast      = (r_y == V_MAX);
    w_xNext      = w_xLast ? 10'd0 : r_x + 10'd1;
    w_yNext      = r_y;
    if (w_xLast) begin
      w_yNext = w_yLast ? 10'd0 : r_y + 10'd1;
    end
    w_hsOn       = ({1'b0, w_xNext} >= HS_START) && ({1'b0, w_xNext} < HS_END);
    w_vsOn       = ({1'b0, w_yNext} >= VS_START) && ({1'b0, w_yNext} < VS_END);
    w_activeNext = ({1'b0, w_xNext} < HA_END) && ({1'b0, w_yNext} < VA_END);
  end

  // Reset parks on the last pixel of the frame so the first enabled edge
  // lands on (0,0) and raises both start strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x          <= H_MAX;
      r_y          <= V_MAX;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_active     <= 1'b0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else if (px_en) begin
      r_x          <= w_xNext;
      r_y          <= w_yNext;
      r_hsync      <= w_hsOn ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_vsOn ? SYNC_POL : ~SYNC_POL;
      r_active     <= w_activeNext;
      r_lineStart  <= w_xLast;
      r_frameStart <= w_xLast && w_yLast;
    end else begin
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end
  end

  assign x_px        = r_x;
  assign y_px        = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign line_start  = r_lineStart;
  assign frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (default 640x480, default-width short
// frame, tiny positive-sync) checked against a position-index reference model.
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       act;
    logic       ls;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic rstD = 1'b0, enD = 1'b0;
  logic rstM = 1'b0, enM = 1'b0;
  logic rstS = 1'b0, enS = 1'b0;
  int   nD = 0, nM = 0, nS = 0;

  logic [9:0] xD, yD, xM, yM, xS, yS;
  logic hsD, vsD, actD, lsD, fsD;
  logic hsM, vsM, actM, lsM, fsM;
  logic hsS, vsS, actS, lsS, fsS;

  vga_timing dutD (
    .clk(clk), .reset(rstD), .px_en(enD), .x_px(xD), .y_px(yD), .hsync(hsD),
    .vsync(vsD), .active(actD), .line_start(lsD), .frame_start(fsD)
  );

  vga_timing #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
  ) dutM (
    .clk(clk), .reset(rstM), .px_en(enM), .x_px(xM), .y_px(yM), .hsync(hsM),
    .vsync(vsM), .active(actM), .line_start(lsM), .frame_start(fsM)
  );

  vga_timing #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
  ) dutS (
    .clk(clk), .reset(rstS), .px_en(enS), .x_px(xS), .y_px(yS), .hsync(hsS),
    .vsync(vsS), .active(actS), .line_start(lsS), .frame_start(fsS)
  );

  // After n enabled edges since reset the raster sits at linear index
  // (n-1) mod frame size; index -1 is the parked last pixel.
  function automatic exp_t model(int n, bit edgeEn, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb, bit pol);
    exp_t e;
    int ht = hv + hf + hsw + hb;
    int vt = vv + vf + vsw + vb;
    int k  = (n + ht * vt - 1) % (ht * vt);
    int x  = k % ht;
    int y  = k / ht;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.hs  = (x >= hv + hf && x < hv + hf + hsw) ? pol : !pol;
    e.vs  = (y >= vv + vf && y < vv + vf + vsw) ? pol : !pol;
    e.act = (x < hv) && (y < vv);
    e.ls  = edgeEn && (x == 0);
    e.fs  = edgeEn && (k == 0);
    return e;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
                     e.x, e.y, e.hs, e.vs, e.act, e.ls, e.fs);
  endfunction

  task automatic test_reset();
    exp_t obs;
    rstD = 1'b0; rstM = 1'b0; rstS = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enD = 1'($urandom_range(0, 1)); enM = 1'($urandom_range(0, 1)); enS = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    nD = 0; nM = 0; nS = 0;
    obs = {xD, yD, hsD, vsD, actD, lsD, fsD};
    checks++;
    if (obs !== {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL reset_default got %s want x=799 y=524 hs=1 vs=1 act=0 ls=0 fs=0", fmt(obs));
    end
    obs = {xM, yM, hsM, vsM, actM, lsM, fsM};
    checks++;
    if (obs !== {10'd799, 10'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL reset_medium got %s want x=799 y=14 hs=1 vs=1 act=0 ls=0 fs=0", fmt(obs));
    end
    obs = {xS, yS, hsS, vsS, actS, lsS, fsS};
    checks++;
    if (obs !== {10'd7, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL reset_small got %s want x=7 y=5 hs=0 vs=0 act=0 ls=0 fs=0", fmt(obs));
    end
    enD = 1'b0; enM = 1'b0; enS = 1'b0;
  endtask

  task automatic test_first_line();
    exp_t obs;
    rstD = 1'b1; enD = 1'b1;
    for (int i = 1; i <= 801; i++) begin
      @(posedge clk); #1;
      nD++;
      obs = {xD, yD, hsD, vsD, actD, lsD, fsD};
      if (i == 1) begin
        checks++;
        if (obs !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
          failures++; $display("[TB] FAIL first_edge got %s want x=0 y=0 hs=1 vs=1 act=1 ls=1 fs=1", fmt(obs));
        end
      end else if (i == 800) begin
        checks++;
        if (obs !== {10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
          failures++; $display("[TB] FAIL line_end got %s want x=799 y=0 act=0", fmt(obs));
        end
      end else if (i == 801) begin
        checks++;
        if (obs !== {10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
          failures++; $display("[TB] FAIL line_wrap got %s want x=0 y=1 act=1 ls=1 fs=0", fmt(obs));
        end
      end
    end
  endtask

  task automatic test_random_default(int cycles);
    exp_t obs, e;
    rstD = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      enD = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      if (enD) nD++;
      e = model(nD, enD, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      obs = {xD, yD, hsD, vsD, actD, lsD, fsD};
      checks++;
      if (obs !== e) begin
        failures++; $display("[TB] FAIL default_rand cyc=%0d got %s want %s", i, fmt(obs), fmt(e));
      end
    end
    enD = 1'b0;
  endtask

  task automatic test_medium_frame();
    exp_t obs, e;
    int sincFs = 0, hsLow = 0, vsLow = 0, actCnt = 0;
    bit seenFs = 0, seenLs = 0;
    rstM = 1'b1; enM = 1'b1;
    for (int i = 0; i < 12010; i++) begin
      @(posedge clk); #1;
      nM++;
      e = model(nM, 1'b1, 640, 16, 96, 48, 8, 2, 2, 3, 1'b0);
      obs = {xM, yM, hsM, vsM, actM, lsM, fsM};
      checks++;
      if (obs !== e) begin
        failures++; $display("[TB] FAIL medium_model cyc=%0d got %s want %s", i, fmt(obs), fmt(e));
      end
      if (lsM) begin
        if (seenLs) begin
          checks++;
          if (hsLow != 96) begin
            failures++; $display("[TB] FAIL medium_hsync_width got %0d want 96", hsLow);
          end
        end
        seenLs = 1; hsLow = 0;
      end
      if (fsM) begin
        if (seenFs) begin
          checks++;
          if ({sincFs, vsLow, actCnt} !== {32'd12000, 32'd1600, 32'd5120}) begin
            failures++;
            $display("[TB] FAIL medium_frame_totals got period=%0d vslow=%0d active=%0d want 12000/1600/5120", sincFs, vsLow, actCnt);
          end
        end
        seenFs = 1; sincFs = 0; vsLow = 0; actCnt = 0;
      end
      sincFs++;
      if (!hsM) hsLow++;
      if (!vsM) vsLow++;
      if (actM) actCnt++;
    end
    checks++;
    if (!seenFs) begin
      failures++; $display("[TB] FAIL medium_no_frame_start got 0 want 1");
    end
    enM = 1'b0;
  endtask

  task automatic test_small_random(int cycles);
    exp_t obs, e;
    rstS = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      enS = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (enS) nS++;
      e = model(nS, enS, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1);
      obs = {xS, yS, hsS, vsS, actS, lsS, fsS};
      checks++;
      if (obs !== e) begin
        failures++; $display("[TB] FAIL small_rand cyc=%0d got %s want %s", i, fmt(obs), fmt(e));
      end
    end
    enS = 1'b0;
  endtask

  task automatic test_small_toggle();
    exp_t obs, e;
    int sincFs = 0, fsSeen = 0;
    rstS = 1'b0; enS = 1'b1;
    @(posedge clk); #1;
    nS = 0; rstS = 1'b1;
    for (int i = 0; i < 200; i++) begin
      enS = (i % 2 == 0);
      @(posedge clk); #1;
      if (enS) nS++;
      e = model(nS, enS, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1);
      obs = {xS, yS, hsS, vsS, actS, lsS, fsS};
      checks++;
      if (obs !== e) begin
        failures++; $display("[TB] FAIL small_toggle cyc=%0d got %s want %s", i, fmt(obs), fmt(e));
      end
      if (fsS) begin
        if (fsSeen > 0) begin
          checks++;
          if (sincFs != 96) begin
            failures++; $display("[TB] FAIL small_toggle_period got %0d want 96", sincFs);
          end
        end
        fsSeen++; sincFs = 0;
      end
      sincFs++;
    end
    checks++;
    if (fsSeen != 3) begin
      failures++; $display("[TB] FAIL small_toggle_frames got %0d want 3", fsSeen);
    end
    enS = 1'b0;
  endtask

  task automatic test_midframe_reset();
    exp_t obs;
    rstS = 1'b0; @(posedge clk); #1;
    rstS = 1'b1; enS = 1'b1;
    for (int i = 0; i < 38; i++) begin
      @(posedge clk); #1;
    end
    obs = {xS, yS, hsS, vsS, actS, lsS, fsS};
    checks++;
    if (obs !== {10'd5, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL small_presync got %s want x=5 y=4 hs=1 vs=1", fmt(obs));
    end
    rstS = 1'b0;
    @(posedge clk); #1;
    obs = {xS, yS, hsS, vsS, actS, lsS, fsS};
    checks++;
    if (obs !== {10'd7, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL small_midreset got %s want x=7 y=5 hs=0 vs=0 act=0", fmt(obs));
    end
    rstS = 1'b1;
    @(posedge clk); #1;
    obs = {xS, yS, hsS, vsS, actS, lsS, fsS};
    checks++;
    if (obs !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
      failures++; $display("[TB] FAIL small_restart got %s want x=0 y=0 act=1 ls=1 fs=1", fmt(obs));
    end
    enS = 1'b0;
    rstD = 1'b0; enD = 1'b1;
    @(posedge clk); #1;
    nD = 0;
    obs = {xD, yD, hsD, vsD, actD, lsD, fsD};
    checks++;
    if (obs !== {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL default_midreset got %s want x=799 y=524 hs=1 vs=1 act=0", fmt(obs));
    end
    rstD = 1'b1; enD = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_random_default(2000);
    test_medium_frame();
    test_small_random(600);
    test_small_toggle();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
